// File: rtl/banco_regis.sv
// banco_regis: general-purpose register file for the single-cycle datapath.
// NUM_REGS registers of DATA_W bits. There are three zero-latency
// combinational read ports (outRA, out1, out2) and one synchronous write port
// gated by EscreveReg. A rising edge with reset=1 clears every register, and
// this takes priority over a write on the same edge.
//
// Optional feature, controlled by the macro BANCO_WRITE_BYPASS_EN:
//   defined   - while a write is pending (EscreveReg=1, reset=0), any read
//               port whose address matches regEscrito returns dadoEscrito
//               before the edge (write-through).
//   undefined - read ports always show the stored contents only.
module banco_regis #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4
) (
    input  logic              EscreveReg,
    input  logic              clock,
    input  logic [ADDR_W-1:0] inRA,
    input  logic [ADDR_W-1:0] in1,
    input  logic [ADDR_W-1:0] in2,
    input  logic [ADDR_W-1:0] regEscrito,
    input  logic [DATA_W-1:0] dadoEscrito,
    output logic [DATA_W-1:0] outRA,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    input  logic              reset
);

    // Storage array; the name is kept stable so benches can reach it hierarchically.
    logic [DATA_W-1:0] registradores [0:NUM_REGS-1];

    // Clear all registers on reset; otherwise store the write data when enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registradores[i] <= '0;
            end
        end else if (EscreveReg) begin
            registradores[regEscrito] <= dadoEscrito;
        end
    end

    // Combinational reads, with an optional forward of the pending write data.
    always_comb begin
        outRA = registradores[inRA];
        out1  = registradores[in1];
        out2  = registradores[in2];
`ifdef BANCO_WRITE_BYPASS_EN
        if (EscreveReg && !reset) begin
            if (inRA == regEscrito) outRA = dadoEscrito;
            if (in1  == regEscrito) out1  = dadoEscrito;
            if (in2  == regEscrito) out2  = dadoEscrito;
        end
`else
`endif
    end

endmodule

// File: tb/tb_banco_regis.sv
// tb_banco_regis: table-driven vectors for banco_regis, plus hand-written
// sequences that cover read-before-edge, the falling edge and reset priority.
module tb_banco_regis;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 4;

    logic              EscreveReg;
    logic              clock;
    logic [ADDR_W-1:0] inRA, in1, in2, regEscrito;
    logic [DATA_W-1:0] dadoEscrito;
    logic [DATA_W-1:0] outRA, out1, out2;
    logic              reset;

    int applied;
    int miscompares;

    banco_regis #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .EscreveReg (EscreveReg),
        .clock      (clock),
        .inRA       (inRA),
        .in1        (in1),
        .in2        (in2),
        .regEscrito (regEscrito),
        .dadoEscrito(dadoEscrito),
        .outRA      (outRA),
        .out1       (out1),
        .out2       (out2),
        .reset      (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              rst;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] r1;
        logic [ADDR_W-1:0] r2;
        logic [DATA_W-1:0] exp_ra;
        logic [DATA_W-1:0] exp_1;
        logic [DATA_W-1:0] exp_2;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    // Compare all three read ports against the expected values; counts as one vector.
    task automatic check3(input string name, input logic [DATA_W-1:0] e_ra,
                          input logic [DATA_W-1:0] e_1, input logic [DATA_W-1:0] e_2);
        logic bad;
        bad = 1'b0;
        applied++;
        if (outRA !== e_ra) begin
            $display("FAIL %s outRA got %0d want %0d", name, outRA, e_ra);
            bad = 1'b1;
        end
        if (out1 !== e_1) begin
            $display("FAIL %s out1 got %0d want %0d", name, out1, e_1);
            bad = 1'b1;
        end
        if (out2 !== e_2) begin
            $display("FAIL %s out2 got %0d want %0d", name, out2, e_2);
            bad = 1'b1;
        end
        if (bad) miscompares++;
    endtask

    // Compare one stored register, read hierarchically, against a value.
    task automatic check_reg(input string name, input int idx, input logic [DATA_W-1:0] e);
        applied++;
        if (dut.registradores[idx] !== e) begin
            $display("FAIL %s registradores[%0d] got %0d want %0d",
                     name, idx, dut.registradores[idx], e);
            miscompares++;
        end
    endtask

    // Drive every input of the DUT.
    task automatic drive(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        reset = rst; EscreveReg = we; regEscrito = wa; dadoEscrito = wd;
        inRA = ra; in1 = r1; in2 = r2;
    endtask

    logic [DATA_W-1:0] exp_pre;

    initial begin
        applied = 0;
        miscompares = 0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);

        // Fields: rst we wa wd ra r1 r2 | outputs expected after the rising edge.
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'd0,   2'd0, 2'd1, 2'd2, 8'd0,   8'd0,   8'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'd3, 8'd12,  2'd3, 2'd1, 2'd2, 8'd12,  8'd0,   8'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 8'd10,  2'd3, 2'd1, 2'd2, 8'd12,  8'd10,  8'd0};
        vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'd11,  2'd3, 2'd1, 2'd2, 8'd12,  8'd10,  8'd11};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 8'd3,   2'd3, 2'd1, 2'd2, 8'd12,  8'd3,   8'd11};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 8'd99,  2'd3, 2'd1, 2'd2, 8'd12,  8'd3,   8'd11};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 8'd99,  2'd3, 2'd1, 2'd2, 8'd12,  8'd3,   8'd11};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 8'd55,  2'd0, 2'd1, 2'd2, 8'd0,   8'd0,   8'd0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'hFF,  2'd0, 2'd0, 2'd0, 8'hFF,  8'hFF,  8'hFF};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 8'd7,   2'd2, 2'd0, 2'd2, 8'd7,   8'hFF,  8'd7};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 8'hA5,  2'd3, 2'd2, 2'd1, 8'hA5,  8'd7,   8'd0};
        vecs[11] = '{1'b0, 1'b1, 2'd1, 8'h5A,  2'd3, 2'd1, 2'd0, 8'hA5,  8'h5A,  8'hFF};

        // Apply each vector at the falling edge and check just after the rising edge.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ra, vecs[i].r1, vecs[i].r2);
            @(posedge clock);
            #1;
            check3($sformatf("vec%0d", i), vecs[i].exp_ra, vecs[i].exp_1, vecs[i].exp_2);
        end

        // Sequence: reset, then preload 3=12, 1=10, 2=11 through the write port.
        @(negedge clock); drive(1'b1, 1'b0, 2'd0, 8'd0,  2'd3, 2'd1, 2'd2);
        @(negedge clock); drive(1'b0, 1'b1, 2'd3, 8'd12, 2'd3, 2'd1, 2'd2);
        @(negedge clock); drive(1'b0, 1'b1, 2'd1, 8'd10, 2'd3, 2'd1, 2'd2);
        @(negedge clock); drive(1'b0, 1'b1, 2'd2, 8'd11, 2'd3, 2'd1, 2'd2);
        @(negedge clock); drive(1'b0, 1'b0, 2'd0, 8'd0,  2'd3, 2'd1, 2'd2);
        #1;
        check3("preload", 8'd12, 8'd10, 8'd11);

        // Write 3 into reg 1: the old value is visible before the edge unless the bypass is built in.
        drive(1'b0, 1'b1, 2'd1, 8'd3, 2'd3, 2'd1, 2'd2);
        #1;
`ifdef BANCO_WRITE_BYPASS_EN
        exp_pre = 8'd3;
`else
        exp_pre = 8'd10;
`endif
        check3("rdw_pre_edge", 8'd12, exp_pre, 8'd11);
        @(posedge clock);
        #1;
        check3("rdw_post_edge", 8'd12, 8'd3, 8'd11);
        check_reg("rdw_store", 1, 8'd3);

        // A falling edge with the write enabled must not store anything.
        drive(1'b0, 1'b1, 2'd2, 8'd77, 2'd3, 2'd1, 2'd2);
        @(negedge clock);
        #1;
        check_reg("falling_edge", 2, 8'd11);
        drive(1'b0, 1'b0, 2'd2, 8'd77, 2'd3, 2'd1, 2'd2);
        @(posedge clock);
        #1;
        check3("we_low_edge", 8'd12, 8'd3, 8'd11);

        // Pending write to reg 2, read on in2 only: out1 stays on its stored value.
        @(negedge clock);
        drive(1'b0, 1'b1, 2'd2, 8'd7, 2'd3, 2'd1, 2'd2);
        #1;
`ifdef BANCO_WRITE_BYPASS_EN
        exp_pre = 8'd7;
`else
        exp_pre = 8'd11;
`endif
        check3("bypass_pre_edge", 8'd12, 8'd3, exp_pre);
        @(posedge clock);
        #1;
        check_reg("bypass_store", 2, 8'd7);

        // Reset together with a write: the reset wins, and no bypass applies while in reset.
        @(negedge clock);
        drive(1'b1, 1'b1, 2'd0, 8'd55, 2'd0, 2'd1, 2'd2);
        #1;
        check3("rst_write_pre_edge", 8'd0, 8'd3, 8'd7);
        @(posedge clock);
        #1;
        check3("rst_write_post_edge", 8'd0, 8'd0, 8'd0);
        check_reg("rst_clears_3", 3, 8'd0);

        @(negedge clock);
        drive(1'b0, 1'b0, 2'd0, 8'd0, 2'd0, 2'd0, 2'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
